// File: rtl/counter_prog_pkg.sv
// Shared encodings for the programmable counter and its prescaler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_prog_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic DIR_DOWN      = 1'b0;
   localparam logic DIR_UP        = 1'b1;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prescaler_rtl.sv
// Step-rate divider: strobes step on the enabled cycle where its count equals limit.
// Latency: step is combinational from the current count; the count wraps to 0 on that edge.
// Backpressure: en=0 freezes the count; clear restarts it from 0.
module prescaler_rtl #(
   parameter int p_pbits = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               en,
   input  logic [p_pbits-1:0] limit,
   output logic               step
);

   logic [p_pbits-1:0] cnt;

   assign step = en && (cnt == limit);

   // Divider count: clear wins over counting, wraps when the limit is reached.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == limit) cnt <= '0;
         else              cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/counter_prog_rtl.sv
// Programmable up/down counter with one-shot or periodic reload, prescaler and terminal tick.
// Latency: count/done/tick are registered; first step P+1 enabled cycles after load.
// Backpressure: en=0 holds count and prescaler while running; idle ignores en.
module counter_prog_rtl
   import counter_prog_pkg::*;
#(
   parameter int p_nbits = 8,
   parameter int p_pbits = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [p_nbits-1:0] in,
   input  logic               up,
   input  logic               periodic,
   input  logic [p_pbits-1:0] prescale,
   input  logic               en,
   output logic [p_nbits-1:0] count,
   output logic               done,
   output logic               tick
);

   localparam logic [p_nbits-1:0] ONE = 1;

   state_t             state, state_nxt;
   logic [p_nbits-1:0] reload_q;
   logic               dir_q;
   logic               mode_q;
   logic [p_pbits-1:0] pre_q;

   logic [p_nbits-1:0] count_nxt;
   logic               tick_nxt;
   logic               step;
   logic               terminal;

   // Prescaler only advances while a count is in progress.
   prescaler_rtl #(.p_pbits(p_pbits)) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clear (load),
      .en    (en && (state == RUN)),
      .limit (pre_q),
      .step  (step)
   );

   // Terminal value: 1 when counting down, reload-1 when counting up.
   assign terminal = (dir_q == DIR_UP) ? ((count + ONE) == reload_q)
                                       : (count == ONE);

   // Configuration captured only on load so mid-run input changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         reload_q <= '0;
         dir_q    <= DIR_DOWN;
         mode_q   <= MODE_ONESHOT;
         pre_q    <= '0;
      end else if (load) begin
         reload_q <= in;
         dir_q    <= up;
         mode_q   <= periodic;
         pre_q    <= prescale;
      end
   end

   // Next state, next count and tick: load restarts, a step moves or wraps the count.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      tick_nxt  = 1'b0;
      if (load) begin
         count_nxt = (up == DIR_UP) ? '0 : in;
         state_nxt = (in == '0) ? IDLE : RUN;
      end else if ((state == RUN) && step) begin
         if (terminal) begin
            tick_nxt = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
               // Terminal value is skipped so the period is exactly N steps.
               count_nxt = (dir_q == DIR_UP) ? '0 : reload_q;
            end else begin
               count_nxt = (dir_q == DIR_UP) ? reload_q : '0;
               state_nxt = IDLE;
            end
         end else begin
            count_nxt = (dir_q == DIR_UP) ? (count + ONE) : (count - ONE);
         end
      end
   end

   // State, count and status registers; done mirrors the idle state after each edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         done  <= 1'b1;
         tick  <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         done  <= (state_nxt == IDLE);
         tick  <= tick_nxt;
      end
   end

endmodule

// File: tb/tb_counter_prog_rtl.sv
// Directed bench for counter_prog_rtl with hand-computed expectations.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: exercised through en toggling mid-run.
module tb_counter_prog_rtl;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [7:0] in;
   logic       up;
   logic       periodic;
   logic [3:0] prescale;
   logic       en;
   logic [7:0] count;
   logic       done;
   logic       tick;

   int n_cmp = 0;
   int n_err = 0;

   counter_prog_rtl #(.p_nbits(8), .p_pbits(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .in       (in),
      .up       (up),
      .periodic (periodic),
      .prescale (prescale),
      .en       (en),
      .count    (count),
      .done     (done),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one edge then compare count/done/tick.
   task automatic step_chk(input string tag, input int ec, input int ed, input int et);
      @(posedge clk);
      #1;
      chk({tag, ".count"}, 32'(count), 32'(ec));
      chk({tag, ".done"},  32'(done),  32'(ed));
      chk({tag, ".tick"},  32'(tick),  32'(et));
   endtask

   task automatic set_load(input logic [7:0] v, input logic u, input logic p, input logic [3:0] ps);
      load = 1'b1; in = v; up = u; periodic = p; prescale = ps;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; in = 8'd0; up = 1'b0; periodic = 1'b0;
      prescale = 4'd0; en = 1'b1;

      // Reset then idle with en=1.
      step_chk("reset", 0, 1, 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step_chk("idle", 0, 1, 0);

      // Down, one-shot, P=0, N=5.
      set_load(8'd5, 1'b0, 1'b0, 4'd0);
      step_chk("dn_load", 5, 0, 0);
      load = 1'b0;
      step_chk("dn4", 4, 0, 0);
      step_chk("dn3", 3, 0, 0);
      step_chk("dn2", 2, 0, 0);
      step_chk("dn1", 1, 0, 0);
      step_chk("dn0", 0, 1, 1);
      step_chk("dn_after", 0, 1, 0);
      step_chk("dn_hold", 0, 1, 0);

      // Up, periodic, P=0, N=3; mid-run config changes must be ignored.
      set_load(8'd3, 1'b1, 1'b1, 4'd0);
      step_chk("up_load", 0, 0, 0);
      load = 1'b0; up = 1'b0; periodic = 1'b0; prescale = 4'd7; in = 8'd1;
      step_chk("up1", 1, 0, 0);
      step_chk("up2", 2, 0, 0);
      step_chk("up_wrap0", 0, 0, 1);
      step_chk("up1b", 1, 0, 0);
      step_chk("up2b", 2, 0, 0);
      step_chk("up_wrap1", 0, 0, 1);
      step_chk("up1c", 1, 0, 0);

      // Down, one-shot, P=2, N=2 with a 2-cycle enable stall.
      set_load(8'd2, 1'b0, 1'b0, 4'd2);
      step_chk("ps_load", 2, 0, 0);
      load = 1'b0;
      step_chk("ps_e1", 2, 0, 0);
      step_chk("ps_e2", 2, 0, 0);
      step_chk("ps_e3", 1, 0, 0);
      step_chk("ps_e4", 1, 0, 0);
      en = 1'b0;
      step_chk("ps_frz1", 1, 0, 0);
      step_chk("ps_frz2", 1, 0, 0);
      en = 1'b1;
      step_chk("ps_e7", 1, 0, 0);
      step_chk("ps_e8", 0, 1, 1);
      step_chk("ps_after", 0, 1, 0);

      // load with in=0, both directions, aborting active runs.
      set_load(8'd7, 1'b0, 1'b0, 4'd0);
      step_chk("z_pre_dn", 7, 0, 0);
      set_load(8'd0, 1'b0, 1'b0, 4'd0);
      step_chk("z_dn", 0, 1, 0);
      load = 1'b0;
      step_chk("z_dn_hold", 0, 1, 0);
      set_load(8'd4, 1'b1, 1'b0, 4'd0);
      step_chk("z_pre_up", 0, 0, 0);
      load = 1'b0;
      step_chk("z_pre_up1", 1, 0, 0);
      set_load(8'd0, 1'b1, 1'b1, 4'd0);
      step_chk("z_up", 0, 1, 0);
      load = 1'b0;
      step_chk("z_up_hold", 0, 1, 0);

      // Reload while running at count=3 (P=1), then reset mid-run.
      set_load(8'd6, 1'b0, 1'b0, 4'd1);
      step_chk("rl_load", 6, 0, 0);
      load = 1'b0;
      step_chk("rl_e1", 6, 0, 0);
      step_chk("rl_e2", 5, 0, 0);
      step_chk("rl_e3", 5, 0, 0);
      step_chk("rl_e4", 4, 0, 0);
      step_chk("rl_e5", 4, 0, 0);
      step_chk("rl_e6", 3, 0, 0);
      step_chk("rl_e7", 3, 0, 0);
      set_load(8'd9, 1'b0, 1'b0, 4'd1);
      step_chk("rl_reload", 9, 0, 0);
      load = 1'b0;
      step_chk("rl_psclr", 9, 0, 0);
      step_chk("rl_step", 8, 0, 0);
      rst = 1'b1;
      step_chk("rst_run", 0, 1, 0);

      // load and rst together: reset wins.
      set_load(8'd5, 1'b0, 1'b0, 4'd0);
      step_chk("rst_vs_load", 0, 1, 0);
      rst = 1'b0; load = 1'b0;
      step_chk("rst_after", 0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
